// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
//   Shared types and constants for the UART TX arbiter slice.
//   - arb_state_e : arbiter FSM states
//   - UART_BYTE_W : width of one UART payload byte
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin picker. Searches the request vector starting at
//   last_gnt_i+1 and wrapping, and returns the first requester found.
// Ports
//   req_i       in  NUM_REQ  request (eligibility) vector
//   last_gnt_i  in  IDX_W    index granted most recently
//   gnt_idx_o   out IDX_W    index of the winner (0 when any_o=0)
//   any_o       out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_gnt_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  localparam int SUM_W = IDX_W + 1;

  // cand_idx[k] is the requester visited k-th in search order.
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_vld;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [SUM_W-1:0] sum;
    // last_gnt+1+gi never exceeds 2*NUM_REQ-1, so one conditional subtract
    // implements the modulo even when NUM_REQ is not a power of two.
    assign sum          = {1'b0, last_gnt_i} + SUM_W'(gi + 1);
    assign cand_idx[gi] = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                   : IDX_W'(sum);
    assign cand_vld[gi] = req_i[cand_idx[gi]];
  end

  // Walk from the far end so the nearest candidate is written last and wins.
  always_comb begin
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_vld[i]) begin
        gnt_idx_o = cand_idx[i];
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART_CORE transmitter among NUM_REQ byte requesters with
//   per-byte round-robin arbitration. Each accepted byte is written to the
//   core with a one-cycle tx_wr pulse; the arbiter then waits for tx_busy to
//   rise (bounded by START_TIMEOUT) and fall before arbitrating again.
//
//   Optional feature macro: UART_ARB_PKT_LOCK_EN
//     When defined, a byte accepted with req_last=0 locks the arbiter to that
//     requester until it delivers a byte with req_last=1. When undefined,
//     req_last is ignored.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   req_valid    in   NUM_REQ       requester i has a byte pending
//   req_data     in   NUM_REQ*8     byte of requester i at [8*i+:8]
//   req_last     in   NUM_REQ       last byte of a packet (lock feature only)
//   req_ready    out  NUM_REQ       one-hot 1-cycle accept strobe
//   gnt_id       out  IDX_W         current / most recent TX owner
//   tx_data      out  8             registered byte to UART_CORE
//   tx_wr        out  1             1-cycle write strobe to UART_CORE
//   tx_empty     in   1             UART_CORE holding register empty
//   tx_busy      in   1             UART_CORE shifting a frame
//   err_timeout  out  1             1-cycle pulse: tx_busy never rose
//   byte_cnt     out  CNT_W         accepted bytes, wraps
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ       = 2,
  parameter  int START_TIMEOUT = 16,
  parameter  int CNT_W         = 16,
  localparam int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [IDX_W-1:0]               gnt_id,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_wr,
  input  logic                           tx_empty,
  input  logic                           tx_busy,
  output logic                           err_timeout,
  output logic [CNT_W-1:0]               byte_cnt
);

  localparam int CTR_W = $clog2(START_TIMEOUT + 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic                   wr_q, wr_d;
  logic [NUM_REQ-1:0]     ready_q, ready_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CTR_W-1:0]       ctr_q, ctr_d;

  logic [UART_BYTE_W-1:0] req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0]     elig;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi]   = req_data[gi*UART_BYTE_W +: UART_BYTE_W];
    assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
  end

`ifdef UART_ARB_PKT_LOCK_EN
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] owner_mask;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
    assign owner_mask[gi] = (gnt_q == IDX_W'(gi));
  end

  // While locked only the packet owner may win; if it has nothing pending the
  // arbiter simply stays in IDLE.
  assign elig = lock_q ? (req_valid & owner_mask) : req_valid;
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign elig            = req_valid;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i      (elig),
    .last_gnt_i (last_gnt_q),
    .gnt_idx_o  (pick_idx),
    .any_o      (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    ready_d    = '0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    ctr_d      = ctr_q;
`ifdef UART_ARB_PKT_LOCK_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      IDLE: begin
        // Strobes are registered on the way into ISSUE so they are high for
        // exactly the one ISSUE cycle.
        if (pick_any && tx_empty && !tx_busy) begin
          gnt_d   = pick_idx;
          data_d  = req_bytes[pick_idx];
          wr_d    = 1'b1;
          ready_d = pick_onehot;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d      = cnt_q + CNT_W'(1);
        last_gnt_d = gnt_q;
        ctr_d      = '0;
`ifdef UART_ARB_PKT_LOCK_EN
        // req_last is still held by the owner during its accept cycle.
        lock_d     = !req_last[gnt_q];
`endif
        state_d    = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
          if (ctr_q == CTR_W'(START_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= IDX_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      ready_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ctr_q      <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      ctr_q      <= ctr_d;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign gnt_id      = gnt_q;
  assign tx_data     = data_q;
  assign tx_wr       = wr_q;
  assign err_timeout = err_q;
  assign byte_cnt    = cnt_q;

endmodule
